// File: rtl/cipher_word_serializer_pkg.sv
// cipher_link_pkg: shared link widths, chunk-count helper and serializer states.
package cipher_link_pkg;
    localparam int PLAIN_W = 60;
    localparam int CIPHER_W = 76;
    localparam int LINK_W = 8;
    typedef enum logic [1:0] {IDLE, SEND, CSUM} ser_state_t;
    function automatic int nchunk(input int in_w, input int out_w);
        return (in_w + out_w - 1) / out_w;
    endfunction
endpackage

// File: rtl/cipher_word_serializer_if.sv
// cipher_word_serializer_if: word-in / chunk-out handshake bundle of the serializer.
interface cipher_word_serializer_if
    import cipher_link_pkg::*;
#(
    parameter int IN_W = CIPHER_W,
    parameter int OUT_W = LINK_W
);
    logic in_valid;
    logic in_ready;
    logic [IN_W-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [OUT_W-1:0] out_data;
    logic out_last;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/cipher_word_serializer_fifo.sv
// cipher_word_fifo: single-clock word FIFO; pushes while full and pops while empty are ignored.
module cipher_word_fifo #(
    parameter int WIDTH = 76,
    parameter int DEPTH = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic push,
    input  logic pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rd_data = mem[rptr];
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr + AW'(do_push);
            rptr <= rptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge Clk) begin
        if (do_push) mem[wptr] <= wr_data;
    end
endmodule

// File: rtl/cipher_word_serializer.sv
// cipher_word_serializer: buffers cipher words and streams them LSB chunk first.
// Define CIPHER_SER_CHECKSUM_EN to append an XOR checksum chunk to every word.
module cipher_word_serializer
    import cipher_link_pkg::*;
#(
    parameter int IN_W = CIPHER_W,
    parameter int OUT_W = LINK_W,
    parameter int DEPTH = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    cipher_word_serializer_if.slave bus,
    output logic busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int NCHUNK = nchunk(IN_W, OUT_W);
    localparam int PW = NCHUNK * OUT_W;
    localparam int IW = $clog2(NCHUNK + 1);
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
    ser_state_t state;
    logic [PW-1:0] shift;
    logic [IW-1:0] chunk_idx;
    logic [IN_W-1:0] head;
    logic full, empty, hs, at_last, word_done, pop;
`ifdef CIPHER_SER_CHECKSUM_EN
    logic [OUT_W-1:0] csum;
`endif
    cipher_word_fifo #(.WIDTH(IN_W), .DEPTH(DEPTH)) u_fifo (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .push(bus.in_valid),
        .pop(pop),
        .wr_data(bus.in_data),
        .rd_data(head),
        .count(fifo_count),
        .full(full),
        .empty(empty)
    );
    assign hs = bus.out_valid && bus.out_ready;
    assign at_last = chunk_idx == LAST;
`ifdef CIPHER_SER_CHECKSUM_EN
    assign word_done = hs && state == CSUM;
    assign bus.out_last = state == CSUM;
    assign bus.out_data = state == CSUM ? csum : shift[OUT_W-1:0];
`else
    assign word_done = hs && at_last;
    assign bus.out_last = state == SEND && at_last;
    assign bus.out_data = shift[OUT_W-1:0];
`endif
    // Popping on the final handshake lets the next word follow without a bubble.
    assign pop = !empty && (state == IDLE || word_done);
    assign bus.in_ready = !full;
    assign busy = !empty || state != IDLE;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            shift <= '0;
            chunk_idx <= '0;
            bus.out_valid <= 1'b0;
`ifdef CIPHER_SER_CHECKSUM_EN
            csum <= '0;
`endif
        end else if (pop) begin
            state <= SEND;
            shift <= PW'(head);
            chunk_idx <= '0;
            bus.out_valid <= 1'b1;
`ifdef CIPHER_SER_CHECKSUM_EN
            csum <= '0;
`endif
        end else if (word_done) begin
            state <= IDLE;
            bus.out_valid <= 1'b0;
        end else if (hs) begin
            shift <= shift >> OUT_W;
            chunk_idx <= chunk_idx + 1'b1;
`ifdef CIPHER_SER_CHECKSUM_EN
            csum <= csum ^ shift[OUT_W-1:0];
            if (at_last) state <= CSUM;
`endif
        end
    end
endmodule

// File: tb/tb_cipher_word_serializer.sv
// tb_cipher_word_serializer: randomized scoreboard bench for the chunk serializer.
module tb_cipher_word_serializer;
    localparam int IN_W = 76;
    localparam int OUT_W = 8;
    localparam int DEPTH = 4;
    localparam int NC = 10;
`ifdef CIPHER_SER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int BPW = NC + CS;

    logic Clk = 0;
    logic Rst_n = 0;
    logic busy;
    logic [$clog2(DEPTH):0] fifo_count;
    int checks = 0;
    int errors = 0;
    int mode = 0;
    int run = 0;
    int max_run = 0;
    int hs_cnt = 0;
    logic [8:0] exp_q[$];
    logic held_v = 0;
    logic [7:0] held_d;
    logic held_l;

    cipher_word_serializer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    cipher_word_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .bus(bus),
        .busy(busy),
        .fifo_count(fifo_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each word becomes its NC zero-padded bytes, LSB first, plus optional XOR byte.
    task automatic add_expected(input logic [IN_W-1:0] w);
        logic [7:0] c;
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < NC; k++) begin
            c = 8'(w >> (8 * k));
            x = x ^ c;
            exp_q.push_back({(k == NC - 1) && (CS == 0), c});
        end
        if (CS == 1) exp_q.push_back({1'b1, x});
    endtask

    task automatic push_word(input logic [IN_W-1:0] w);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = w;
        while (!bus.in_ready && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        check("push_accept", n < 2000, 1'b1);
        add_expected(w);
        @(negedge Clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_busy", busy, 1'b0);
    endtask

    always @(posedge Clk) begin
        #1;
        bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~bus.out_ready : mode == 2 ? 1'($urandom) : 1'b0;
    end

    always @(negedge Clk) begin
        logic [8:0] e;
        if (!Rst_n) begin
            held_v = 1'b0;
            run = 0;
        end else begin
            if (held_v) begin
                check("stall_valid", bus.out_valid, 1'b1);
                check("stall_data", bus.out_data, held_d);
                check("stall_last", bus.out_last, held_l);
            end
            held_v = bus.out_valid && !bus.out_ready;
            held_d = bus.out_data;
            held_l = bus.out_last;
            run = bus.out_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", bus.out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", bus.out_data, e[7:0]);
                    check("beat_last", bus.out_last, e[8]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, base;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 8'h00);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("idle_valid", bus.out_valid, 1'b0);

        mode = 0;
        push_word(76'h1_2345_6789_ABCD_EF01_23);
        check("lat_valid_early", bus.out_valid, 1'b0);
        check("lat_count", fifo_count, 1);
        check("lat_busy", busy, 1'b1);
        @(negedge Clk);
        check("lat_valid", bus.out_valid, 1'b1);
        check("lat_first", bus.out_data, 8'h23);
        check("lat_count_pop", fifo_count, 0);
        wait_drain();

        mode = 1;
        push_word({IN_W{1'b1}});
        wait_drain();

        mode = 3;
        for (int i = 0; i < 5; i++) push_word({$urandom, $urandom, $urandom});
        repeat (3) @(negedge Clk);
        check("full_count", fifo_count, 4);
        check("full_in_ready", bus.in_ready, 1'b0);
        check("full_stalled", bus.out_valid, 1'b1);
        mode = 0;
        @(posedge Clk);
        #2;
        run = 0;
        max_run = 0;
        wait_drain();
        check("no_gap_run", max_run, 5 * BPW);

        base = hs_cnt;
        mode = 0;
        for (int i = 0; i < 3; i++) push_word({$urandom, $urandom, $urandom});
        n = 0;
        while (hs_cnt < base + 4 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("pre_reset_count", fifo_count, 2);
        @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", busy, 1'b0);
        exp_q.delete();
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (20) @(negedge Clk);
        check("post_rst_valid", bus.out_valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        mode = 3;
        for (int i = 0; i < 3; i++) push_word({$urandom, $urandom, $urandom});
        @(negedge Clk);
        check("pp_count_before", fifo_count, 2);
        mode = 0;
        n = 0;
        while (!(bus.out_valid && bus.out_last && bus.out_ready) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("pp_found_last", n < 200, 1'b1);
        push_word({$urandom, $urandom, $urandom});
        check("pp_count_after", fifo_count, 2);
        wait_drain();

        mode = 2;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            push_word({$urandom, $urandom, $urandom});
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
